// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word-aligned request at a
// time to instruction memory and buffers {pc, instr} pairs in a small FIFO for decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [63:0] if_pc,
  input  logic        if_ready
);

  localparam int         PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);

  typedef enum logic [1:0] {REQ, WAIT, DISCARD} state_t;

  state_t           state;
  logic [63:0]      fetch_pc;
  logic [63:0]      issued_pc;
  logic [2:0]       count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [63:0]      pc_q    [QUEUE_DEPTH];
  logic [31:0]      instr_q [QUEUE_DEPTH];

  logic handshake;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request is gated by rst so it drops the instant reset is asserted.
  assign imem_req_valid = !rst && (state == REQ) && (count < DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign if_valid       = (count != 3'd0) && !redirect_valid;
  assign if_instruction = instr_q[head];
  assign if_pc          = pc_q[head];

  assign push = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop  = if_valid && if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REQ;
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~64'h3;
      case (state)
        REQ:     state <= handshake ? DISCARD : REQ;
        WAIT:    state <= imem_resp_valid ? REQ : DISCARD;
        default: state <= imem_resp_valid ? REQ : DISCARD;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (handshake) begin
            issued_pc <= fetch_pc;
            fetch_pc  <= fetch_pc + 64'd4;
            state     <= WAIT;
          end
        end
        WAIT:    if (imem_resp_valid) state <= REQ;
        default: if (imem_resp_valid) state <= REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 3'd0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]    <= 64'd0;
        instr_q[i] <= 32'd0;
      end
    end else if (redirect_valid) begin
      count <= 3'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        pc_q[tail]    <= issued_pc;
        instr_q[tail] <= imem_resp_data;
        tail          <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed checks of fetch_unit: per-cycle vector table plus hand-written
// sequences for PC wrap-around and asynchronous reset mid-transaction.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;
  logic        if_ready = 1'b0;

  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_req_ready = 1'b0;
  logic        w_resp_valid = 1'b0;
  logic [31:0] w_resp_data = 32'd0;
  logic        w_if_valid;
  logic [31:0] w_if_instruction;
  logic [63:0] w_if_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc),
    .if_ready(if_ready)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QUEUE_DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(64'd0),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_req_ready),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .if_valid(w_if_valid), .if_instruction(w_if_instruction), .if_pc(w_if_pc),
    .if_ready(1'b0)
  );

  typedef struct {
    logic        rst_before;
    logic        redir;
    logic [63:0] redir_pc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        ifr;
    logic        e_req_valid;
    logic [63:0] e_req_addr;
    logic        e_if_valid;
    logic [63:0] e_if_pc;
    logic [31:0] e_if_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rb, input logic rd, input logic [63:0] rpc,
                     input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic ifr, input logic erv, input logic [63:0] eaddr,
                     input logic eifv, input logic [63:0] epc, input logic [31:0] einstr);
    vec_t v;
    v.rst_before = rb; v.redir = rd; v.redir_pc = rpc; v.req_ready = rdy;
    v.resp_valid = rv; v.resp_data = rdata; v.ifr = ifr;
    v.e_req_valid = erv; v.e_req_addr = eaddr; v.e_if_valid = eifv;
    v.e_if_pc = epc; v.e_if_instr = einstr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0; redirect_pc = 64'd0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0; if_ready = 1'b0;
    w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = 32'd0;
  endtask

  // Ends at a negedge with rst just released; caller drives that cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_req_valid", -1, 64'(imem_req_valid), 64'd0);
    check("rst_if_valid", -1, 64'(if_valid), 64'd0);
    check("rst_req_addr", -1, imem_req_addr, 64'd0);
    check("rst_if_pc", -1, if_pc, 64'd0);
    check("rst_if_instr", -1, 64'(if_instruction), 64'd0);
    check("rst_wrap_addr", -1, w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Zero-wait memory, decode always ready
    add(1,0,0,      1,0,32'h0,       1, 1,64'h0,  0,0,0);
    add(0,0,0,      1,1,32'h00500093,1, 0,64'h4,  0,0,0);
    add(0,0,0,      1,0,32'h0,       1, 1,64'h4,  1,64'h0,32'h00500093);
    add(0,0,0,      1,1,32'h00A00113,1, 0,64'h8,  0,0,0);
    add(0,0,0,      1,0,32'h0,       1, 1,64'h8,  1,64'h4,32'h00A00113);
    add(0,0,0,      1,1,32'h00F00193,1, 0,64'hC,  0,0,0);
    add(0,0,0,      0,0,32'h0,       1, 1,64'hC,  1,64'h8,32'h00F00193);
    // Decode backpressure fills the queue, requests stall until pops
    add(1,0,0,      1,0,32'h0,       0, 1,64'h0,  0,0,0);
    add(0,0,0,      1,1,32'h00500093,0, 0,64'h4,  0,0,0);
    add(0,0,0,      1,0,32'h0,       0, 1,64'h4,  1,64'h0,32'h00500093);
    add(0,0,0,      1,1,32'h00A00113,0, 0,64'h8,  1,64'h0,32'h00500093);
    add(0,0,0,      1,0,32'h0,       0, 0,64'h8,  1,64'h0,32'h00500093);
    add(0,0,0,      1,0,32'h0,       0, 0,64'h8,  1,64'h0,32'h00500093);
    add(0,0,0,      1,0,32'h0,       1, 0,64'h8,  1,64'h0,32'h00500093);
    add(0,0,0,      1,0,32'h0,       1, 1,64'h8,  1,64'h4,32'h00A00113);
    add(0,0,0,      0,0,32'h0,       1, 0,64'hC,  0,0,0);
    // Redirect while waiting for 0x4; late response is dropped
    add(1,0,0,      1,0,32'h0,       1, 1,64'h0,  0,0,0);
    add(0,0,0,      1,1,32'h00500093,1, 0,64'h4,  0,0,0);
    add(0,0,0,      1,0,32'h0,       1, 1,64'h4,  1,64'h0,32'h00500093);
    add(0,1,64'h100,1,0,32'h0,       1, 0,64'h8,  0,0,0);
    add(0,0,0,      1,0,32'h0,       1, 0,64'h100,0,0,0);
    add(0,0,0,      1,0,32'h0,       1, 0,64'h100,0,0,0);
    add(0,0,0,      1,1,32'hDEADBEEF,1, 0,64'h100,0,0,0);
    add(0,0,0,      1,0,32'h0,       1, 1,64'h100,0,0,0);
    add(0,0,0,      1,1,32'h11111111,1, 0,64'h104,0,0,0);
    add(0,0,0,      0,0,32'h0,       1, 1,64'h104,1,64'h100,32'h11111111);
    // Misaligned redirect coincident with handshake for 0x8
    add(1,0,0,      1,0,32'h0,       1, 1,64'h0,  0,0,0);
    add(0,0,0,      1,1,32'h00500093,1, 0,64'h4,  0,0,0);
    add(0,0,0,      1,0,32'h0,       1, 1,64'h4,  1,64'h0,32'h00500093);
    add(0,0,0,      1,1,32'h00A00113,1, 0,64'h8,  0,0,0);
    add(0,1,64'h103,1,0,32'h0,       1, 1,64'h8,  0,0,0);
    add(0,0,0,      0,1,32'h22222222,1, 0,64'h100,0,0,0);
    add(0,0,0,      0,0,32'h0,       1, 1,64'h100,0,0,0);
    add(0,0,0,      0,0,32'h0,       1, 1,64'h100,0,0,0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      else @(negedge clk);
      redirect_valid  = vecs[i].redir;
      redirect_pc     = vecs[i].redir_pc;
      imem_req_ready  = vecs[i].req_ready;
      imem_resp_valid = vecs[i].resp_valid;
      imem_resp_data  = vecs[i].resp_data;
      if_ready        = vecs[i].ifr;
      #1;
      check("req_valid", i, 64'(imem_req_valid), 64'(vecs[i].e_req_valid));
      check("req_addr", i, imem_req_addr, vecs[i].e_req_addr);
      check("if_valid", i, 64'(if_valid), 64'(vecs[i].e_if_valid));
      if (vecs[i].e_if_valid) begin
        check("if_pc", i, if_pc, vecs[i].e_if_pc);
        check("if_instr", i, 64'(if_instruction), 64'(vecs[i].e_if_instr));
      end
    end

    // PC wrap-around from the top of the address space
    do_reset();
    w_req_ready = 1'b1;
    #1;
    check("wrap_req_valid0", 0, 64'(w_req_valid), 64'd1);
    check("wrap_req_addr0", 0, w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    w_req_ready = 1'b0; w_resp_valid = 1'b1; w_resp_data = 32'h44444444;
    #1;
    check("wrap_req_valid1", 1, 64'(w_req_valid), 64'd0);
    check("wrap_req_addr1", 1, w_req_addr, 64'h0);
    @(negedge clk);
    w_resp_valid = 1'b0;
    #1;
    check("wrap_req_valid2", 2, 64'(w_req_valid), 64'd1);
    check("wrap_req_addr2", 2, w_req_addr, 64'h0);
    check("wrap_if_valid", 2, 64'(w_if_valid), 64'd1);
    check("wrap_if_pc", 2, w_if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_if_instr", 2, 64'(w_if_instruction), 64'h44444444);

    // Asynchronous reset while waiting with one entry queued
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00500093;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #1;
    check("ar_pre_if_valid", 0, 64'(if_valid), 64'd1);
    check("ar_pre_req_valid", 0, 64'(imem_req_valid), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_if_valid", 1, 64'(if_valid), 64'd0);
    check("ar_req_valid", 1, 64'(imem_req_valid), 64'd0);
    check("ar_req_addr", 1, imem_req_addr, 64'h0);
    check("ar_if_pc", 1, if_pc, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBADBAD00;
    #1;
    check("ar_rel_req_valid", 2, 64'(imem_req_valid), 64'd1);
    check("ar_rel_req_addr", 2, imem_req_addr, 64'h0);
    @(negedge clk);
    imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    check("ar_stale_if_valid", 3, 64'(if_valid), 64'd0);
    check("ar_stale_req_valid", 3, 64'(imem_req_valid), 64'd1);
    check("ar_stale_req_addr", 3, imem_req_addr, 64'h0);
    @(negedge clk);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h33333333;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    check("ar_new_if_valid", 4, 64'(if_valid), 64'd1);
    check("ar_new_if_pc", 4, if_pc, 64'h0);
    check("ar_new_if_instr", 4, 64'(if_instruction), 64'h33333333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the single-cycle/sequential RV64 core: owns the program counter and issues word-aligned fetch requests to instruction memory over a valid/ready handshake. Returned instructions are buffered with their PCs in a small queue feeding `instruction_decode_stage`. Taken-branch redirects from the execute stage flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, 64'h0: PC fetched first after reset (bits [1:0] must be 0).
- `QUEUE_DEPTH`, 2: instruction queue entries; legal range 1–4.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect_valid`  in  1  taken branch/jump; highest priority.
- `redirect_pc`  in  64  redirect target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  64  fetch byte address, always word-aligned.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_resp_valid`  in  1  response valid, one cycle per response.
- `imem_resp_data`  in  32  fetched instruction.
- `if_valid`  out  1  queue head valid toward decode.
- `if_instruction`  out  32  queue head instruction.
- `if_pc`  out  64  queue head PC.
- `if_ready`  in  1  decode accepts head.

## Operation
- Registers: `fetch_pc` (64), FSM state, queue of {pc, instr} with `count`.
- States:
  - REQ: `imem_req_valid = (count < QUEUE_DEPTH)`; `imem_req_addr = fetch_pc`. On handshake: `fetch_pc += 4` and go to WAIT.
  - WAIT: `imem_req_valid = 0`. On `imem_resp_valid`: enqueue {issued pc, data} and go to REQ.
  - DISCARD: `imem_req_valid = 0`. On `imem_resp_valid`: drop data and go to REQ.
- At most one request is outstanding. Entry to WAIT requires `count < QUEUE_DEPTH`, so an enqueue never overflows, including a same-cycle dequeue.
- The issued PC is latched at handshake for tagging the response.
- PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Redirect (`redirect_valid = 1`) overrides every other event in the same cycle:
  - Next `fetch_pc = {redirect_pc[63:2], 2'b00}`; misaligned low bits are cleared.
  - Queue is flushed (`count = 0`); a same-cycle pop or enqueue is ignored.
  - Next state: from REQ with handshake this cycle, DISCARD. From REQ without handshake, REQ. From WAIT without response, DISCARD. From WAIT with response this cycle, REQ (response dropped). From DISCARD, DISCARD, or REQ if the response arrives this cycle.
- `if_valid = (count != 0) && !redirect_valid`. Pop occurs when `if_valid && if_ready`.
- `imem_resp_valid` in REQ state is ignored (stale traffic after reset).
- Reset values:
  - FSM state REQ; `fetch_pc = RESET_PC`; `count = 0`.
  - `imem_req_valid = 0`, `imem_req_addr = RESET_PC`.
  - `if_valid = 0`, `if_instruction = 0`, `if_pc = 0`.
  - `imem_req_valid` is forced low while `rst` is high.

## Timing
- First request is asserted in the first cycle after `rst` deasserts.
- Request: `valid` and `addr` are held stable until `ready`; no retraction except on redirect.
- Response is accepted the cycle after handshake at the earliest. An enqueued entry is visible on `if_*` the cycle after `imem_resp_valid`.
- Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Queue is FIFO. Head outputs are combinational from registered storage.
- Redirect: the first request to the new PC appears the next cycle if no request is outstanding. Otherwise it appears the cycle after the discarded response.
- Async reset mid-transaction: all outputs take reset values immediately, without waiting for a clock edge; an outstanding response is later ignored.

## Test plan
- Zero-wait memory, response 1 cycle after handshake, `if_ready = 1`: request addresses 0x0, 0x4, 0x8. `if_pc`/`if_instruction` = 0x0/0x00500093, then 0x4/0x00A00113, in order.
- Backpressure with `if_ready = 0`: after 2 enqueues, `imem_req_valid` stays 0 indefinitely. Raise `if_ready`: 0x0 then 0x4 pop, and the next request addr is 0x8.
- Redirect to 0x100 while in WAIT for 0x4; response 0xDEADBEEF arrives 3 cycles later. Required: it is dropped, the next request is 0x100, and `if_pc` never shows 0x4.
- Redirect to 0x103 in the same cycle as a request handshake for 0x8. Required: the 0x8 response is discarded and the next request addr is 0x100.
- `RESET_PC` = 64'hFFFF_FFFF_FFFF_FFFC: request addresses FFFF_FFFF_FFFF_FFFC, then 0x0.
- Assert `rst` between edges while in WAIT: `imem_req_valid`/`if_valid` go to 0 immediately. A stale response in the cycle after release is ignored, and the first request addr is `RESET_PC`.
